// File: rtl/uart_pkg.sv
// Shared UART definitions.
//   UART_SIZE   - default receive word width in bits
//   RXBUF_DEPTH - default receive buffer capacity in words
//   ERRCNT_W    - width of the parity-error event counter
//   rx_state_t  - receiver FSM state encodings
//   sat_inc_err - saturating increment for the error counter
package uart_pkg;

    localparam int UART_SIZE   = 32;
    localparam int RXBUF_DEPTH = 8;
    localparam int ERRCNT_W    = 8;

    typedef enum logic [2:0] {
        RX_IDLE   = 3'd0,
        RX_START  = 3'd1,
        RX_DATA   = 3'd2,
        RX_PARITY = 3'd3,
        RX_STOP   = 3'd4
    } rx_state_t;

    // The counter holds at all-ones once it gets there.
    function automatic logic [ERRCNT_W-1:0] sat_inc_err(input logic [ERRCNT_W-1:0] v);
        return (v == {ERRCNT_W{1'b1}}) ? v : v + ERRCNT_W'(1);
    endfunction

endpackage

// File: rtl/uart_rx_buffer_if.sv
// Receive-buffer data path bundle.
//   RxData/RxDone/RxFlag - from the UART receiver (DataOut, DoneRx level, parity flag)
//   RdData/RdValid       - head-of-FIFO word to the consumer, first-word-fall-through
//   RdReady              - consumer accepts the head word
// master: the side driving the receiver signals and RdReady (receiver + consumer).
// slave : the buffer itself.
interface uart_rx_buffer_if #(
    parameter int SIZE = 32
);
    logic [SIZE-1:0] RxData;
    logic            RxDone;
    logic            RxFlag;
    logic            RdReady;
    logic [SIZE-1:0] RdData;
    logic            RdValid;

    modport master (
        output RxData, RxDone, RxFlag, RdReady,
        input  RdData, RdValid
    );

    modport slave (
        input  RxData, RxDone, RxFlag, RdReady,
        output RdData, RdValid
    );
endinterface

// File: rtl/rxbuf_mem.sv
// Receive buffer storage: DEPTH x SIZE words.
//   CLK_Baudin - write clock
//   wr_en      - write wr_data at wr_addr on the rising edge
//   wr_addr    - write address
//   wr_data    - write data
//   rd_addr    - read address
//   rd_data    - mem[rd_addr], combinational (asynchronous read)
// Contents are deliberately not reset; words only change when written.
module rxbuf_mem #(
    parameter int SIZE  = 32,
    parameter int DEPTH = 8
) (
    input  logic                     CLK_Baudin,
    input  logic                     wr_en,
    input  logic [$clog2(DEPTH)-1:0] wr_addr,
    input  logic [SIZE-1:0]          wr_data,
    input  logic [$clog2(DEPTH)-1:0] rd_addr,
    output logic [SIZE-1:0]          rd_data
);
    logic [SIZE-1:0] mem [DEPTH];

    always_ff @(posedge CLK_Baudin) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    // Asynchronous read gives the FIFO its fall-through behaviour.
    assign rd_data = mem[rd_addr];
endmodule

// File: rtl/uart_rx_buffer.sv
// UART receive FIFO. Captures one word per rising edge of the receiver's
// DoneRx level and presents it to a consumer with a valid/ready handshake.
//   CLK_Baudin - baud clock, all state on its rising edge
//   RstRx      - asynchronous active-high reset
//   ClrErr     - synchronous clear of Overflow and ErrCnt
//   bus        - receiver inputs and consumer handshake (slave modport)
//   Count      - words stored
//   Full/Empty - Count==DEPTH / Count==0
//   Overflow   - sticky: a word arrived while full with no pop
//   ErrCnt     - saturating count of RxFlag rising edges
// DEPTH must be a power of two, at least 2, so pointers wrap by overflow.
module uart_rx_buffer
    import uart_pkg::*;
#(
    parameter int SIZE  = UART_SIZE,
    parameter int DEPTH = RXBUF_DEPTH
) (
    input  logic                     CLK_Baudin,
    input  logic                     RstRx,
    input  logic                     ClrErr,
    uart_rx_buffer_if.slave          bus,
    output logic [$clog2(DEPTH):0]   Count,
    output logic                     Full,
    output logic                     Empty,
    output logic                     Overflow,
    output logic [ERRCNT_W-1:0]      ErrCnt
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic                done_prev_reg;
    logic                flag_prev_reg;
    logic [PTR_W-1:0]    wr_ptr_reg, wr_ptr_next;
    logic [PTR_W-1:0]    rd_ptr_reg, rd_ptr_next;
    logic [CNT_W-1:0]    count_reg, count_next;
    logic                overflow_reg, overflow_next;
    logic [ERRCNT_W-1:0] errcnt_reg, errcnt_next;

    logic push, err, pop, wr_en, ovf_evt, empty, full;

    // DoneRx stays high for many cycles; only its rising edge is a new word.
    assign push  = bus.RxDone & ~done_prev_reg;
    assign err   = bus.RxFlag & ~flag_prev_reg;

    assign empty = (count_reg == '0);
    assign full  = (count_reg == CNT_W'(DEPTH));

    // A pop needs a stored word; RdReady while empty is ignored.
    assign pop     = ~empty & bus.RdReady;
    // When full, a simultaneous pop frees the slot being written.
    assign wr_en   = push & (~full | pop);
    assign ovf_evt = push & full & ~pop;

    rxbuf_mem #(
        .SIZE  (SIZE),
        .DEPTH (DEPTH)
    ) u_mem (
        .CLK_Baudin (CLK_Baudin),
        .wr_en      (wr_en),
        .wr_addr    (wr_ptr_reg),
        .wr_data    (bus.RxData),
        .rd_addr    (rd_ptr_reg),
        .rd_data    (bus.RdData)
    );

    always_comb begin
        wr_ptr_next   = wr_ptr_reg;
        rd_ptr_next   = rd_ptr_reg;
        count_next    = count_reg;
        overflow_next = overflow_reg;
        errcnt_next   = errcnt_reg;

        if (wr_en) begin
            wr_ptr_next = wr_ptr_reg + PTR_W'(1);
        end
        if (pop) begin
            rd_ptr_next = rd_ptr_reg + PTR_W'(1);
        end

        if (wr_en && !pop) begin
            count_next = count_reg + CNT_W'(1);
        end else if (!wr_en && pop) begin
            count_next = count_reg - CNT_W'(1);
        end

        // A new event in the same cycle as ClrErr is kept, not cleared.
        if (ovf_evt) begin
            overflow_next = 1'b1;
        end else if (ClrErr) begin
            overflow_next = 1'b0;
        end

        if (ClrErr) begin
            errcnt_next = err ? ERRCNT_W'(1) : '0;
        end else if (err) begin
            errcnt_next = sat_inc_err(errcnt_reg);
        end
    end

    always_ff @(posedge CLK_Baudin or posedge RstRx) begin
        if (RstRx) begin
            done_prev_reg <= 1'b0;
            flag_prev_reg <= 1'b0;
            wr_ptr_reg    <= '0;
            rd_ptr_reg    <= '0;
            count_reg     <= '0;
            overflow_reg  <= 1'b0;
            errcnt_reg    <= '0;
        end else begin
            done_prev_reg <= bus.RxDone;
            flag_prev_reg <= bus.RxFlag;
            wr_ptr_reg    <= wr_ptr_next;
            rd_ptr_reg    <= rd_ptr_next;
            count_reg     <= count_next;
            overflow_reg  <= overflow_next;
            errcnt_reg    <= errcnt_next;
        end
    end

    assign bus.RdValid = ~empty;
    assign Count       = count_reg;
    assign Full        = full;
    assign Empty       = empty;
    assign Overflow    = overflow_reg;
    assign ErrCnt      = errcnt_reg;
endmodule

// File: tb/tb_uart_rx_buffer.sv
module tb_uart_rx_buffer;
    import uart_pkg::*;

    localparam int SIZE  = 32;
    localparam int DEPTH = 8;

    logic                CLK_Baudin = 1'b0;
    logic                RstRx      = 1'b1;
    logic                ClrErr     = 1'b0;
    logic [3:0]          Count;
    logic                Full, Empty, Overflow;
    logic [ERRCNT_W-1:0] ErrCnt;

    uart_rx_buffer_if #(.SIZE(SIZE)) bus ();

    uart_rx_buffer #(.SIZE(SIZE), .DEPTH(DEPTH)) dut (
        .CLK_Baudin (CLK_Baudin),
        .RstRx      (RstRx),
        .ClrErr     (ClrErr),
        .bus        (bus.slave),
        .Count      (Count),
        .Full       (Full),
        .Empty      (Empty),
        .Overflow   (Overflow),
        .ErrCnt     (ErrCnt)
    );

    always #5 CLK_Baudin = ~CLK_Baudin;

    int checks = 0;
    int errors = 0;
    logic [SIZE-1:0] exp_q [$];

    task automatic check(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end else begin
            $display("ok   %s: %0h", name, act);
        end
    endtask

    // Scoreboard monitor: a pop happens at the next rising edge whenever
    // RdValid and RdReady are both high at the falling edge.
    initial begin
        forever begin
            @(negedge CLK_Baudin);
            if (!RstRx && bus.RdValid && bus.RdReady) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL pop_unexpected: got %h expected no word", bus.RdData);
                end else begin
                    check("pop_data", longint'(bus.RdData), longint'(exp_q.pop_front()));
                end
            end
        end
    end

    task automatic tick();
        @(posedge CLK_Baudin);
        #1;
    endtask

    // Raise RxDone with data for 'hold' edges, then drop it for one edge.
    task automatic send_word(input logic [SIZE-1:0] data, input int hold);
        bus.RxData = data;
        bus.RxDone = 1'b1;
        repeat (hold) tick();
        bus.RxDone = 1'b0;
        tick();
    endtask

    task automatic drain();
        int n;
        n = 0;
        bus.RdReady = 1'b1;
        while (!Empty && n < 40) begin
            tick();
            n++;
        end
        bus.RdReady = 1'b0;
        check("drain_empty", longint'(Empty), 1);
    endtask

    initial begin
        logic [SIZE-1:0] d;
        bus.RxData  = '0;
        bus.RxDone  = 1'b0;
        bus.RxFlag  = 1'b0;
        bus.RdReady = 1'b0;

        // Reset state
        #3;
        check("rst_empty",    longint'(Empty), 1);
        check("rst_full",     longint'(Full), 0);
        check("rst_valid",    longint'(bus.RdValid), 0);
        check("rst_count",    longint'(Count), 0);
        check("rst_overflow", longint'(Overflow), 0);
        check("rst_errcnt",   longint'(ErrCnt), 0);
        tick();
        RstRx = 1'b0;
        tick();

        // Single word, RxDone held 5 cycles -> exactly one push
        bus.RxData = 32'hDEADBEEF;
        bus.RxDone = 1'b1;
        exp_q.push_back(32'hDEADBEEF);
        tick();
        check("single_count1", longint'(Count), 1);
        check("single_valid",  longint'(bus.RdValid), 1);
        check("single_data",   longint'(bus.RdData), 64'hDEADBEEF);
        repeat (4) tick();
        bus.RxDone = 1'b0;
        tick();
        check("single_count_hold", longint'(Count), 1);
        drain();

        // Fill and overflow: 9 words, word 9 dropped
        for (int i = 1; i <= 9; i++) begin
            send_word(SIZE'(i), 1);
            if (i <= 8) exp_q.push_back(SIZE'(i));
            if (i == 8) begin
                check("fill_full",  longint'(Full), 1);
                check("fill_count", longint'(Count), 8);
                check("fill_ovf0",  longint'(Overflow), 0);
            end
        end
        check("ovf_set",   longint'(Overflow), 1);
        check("ovf_count", longint'(Count), 8);
        drain();
        check("ovf_sticky", longint'(Overflow), 1);
        ClrErr = 1'b1;
        tick();
        ClrErr = 1'b0;
        check("ovf_cleared", longint'(Overflow), 0);

        // Full with simultaneous push and pop
        for (int i = 1; i <= 8; i++) begin
            send_word(SIZE'(i), 1);
            exp_q.push_back(SIZE'(i));
        end
        bus.RxData  = 32'd9;
        bus.RxDone  = 1'b1;
        bus.RdReady = 1'b1;
        exp_q.push_back(32'd9);
        tick();
        bus.RdReady = 1'b0;
        bus.RxDone  = 1'b0;
        check("pp_count",    longint'(Count), 8);
        check("pp_full",     longint'(Full), 1);
        check("pp_overflow", longint'(Overflow), 0);
        drain();

        // Wrap: 20 push/pop pairs, consumer always ready
        bus.RdReady = 1'b1;
        for (int i = 0; i < 20; i++) begin
            d = $urandom;
            exp_q.push_back(d);
            send_word(d, 1);
            check("wrap_count", longint'(Count), 0);
        end
        bus.RdReady = 1'b0;
        tick();

        // Errors: one stored word survives 300 flag events
        send_word(32'h0BADF00D, 1);
        exp_q.push_back(32'h0BADF00D);
        for (int i = 0; i < 300; i++) begin
            bus.RxFlag = 1'b1;
            tick();
            bus.RxFlag = 1'b0;
            tick();
        end
        check("err_saturate", longint'(ErrCnt), 255);
        check("err_keep_word", longint'(Count), 1);
        bus.RxFlag = 1'b1;
        ClrErr     = 1'b1;
        tick();
        bus.RxFlag = 1'b0;
        ClrErr     = 1'b0;
        check("err_clr_coincident", longint'(ErrCnt), 1);
        ClrErr = 1'b1;
        tick();
        ClrErr = 1'b0;
        check("err_clr", longint'(ErrCnt), 0);
        drain();

        // Reset mid-operation
        for (int i = 0; i < 5; i++) begin
            send_word(32'hC0DE0000 + SIZE'(i), 1);
            exp_q.push_back(32'hC0DE0000 + SIZE'(i));
        end
        check("mid_count5", longint'(Count), 5);
        #2;
        RstRx = 1'b1;
        exp_q.delete();
        #1;
        check("mid_rst_empty", longint'(Empty), 1);
        check("mid_rst_valid", longint'(bus.RdValid), 0);
        check("mid_rst_count", longint'(Count), 0);
        bus.RxData = 32'hA5A50001;
        bus.RxDone = 1'b1;
        tick();
        RstRx = 1'b0;
        exp_q.push_back(32'hA5A50001);
        tick();
        check("rel_push_count", longint'(Count), 1);
        bus.RxDone = 1'b0;
        tick();
        check("rel_one_push", longint'(Count), 1);
        drain();

        tick();
        check("scoreboard_empty", longint'(exp_q.size()), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
